// File: rtl/tm1638_emu.sv
// TM1638 display/key controller emulator: decodes the host's 3-wire serial frames into
// display RAM and display-control registers, and shifts key-scan bytes back on read.
module tm1638_emu #(
  parameter int SYNC_STAGES = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_tm1638_clk,
  input  logic         i_tm1638_stb,
  input  logic         i_tm1638_dio,
  output logic         o_tm1638_dio,
  output logic         o_tm1638_dio_oe,
  input  logic [31:0]  i_key_scan,
  output logic [127:0] o_disp_ram,
  output logic         o_display_on,
  output logic [2:0]   o_brightness,
  output logic         o_wr_strobe,
  output logic [3:0]   o_wr_addr,
  output logic         o_frame_err,
  output logic         o_idle
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_WRITE  = 3'd2,
    S_READ   = 3'd3,
    S_IGNORE = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] stb_sync_q;
  logic [SYNC_STAGES-1:0] dio_sync_q;
  logic                   clk_prev_q;
  logic                   stb_prev_q;

  logic clk_s;
  logic stb_s;
  logic dio_s;
  logic clk_rise_s;
  logic clk_fall_s;
  logic stb_rise_s;
  logic stb_fall_s;

  state_t      state_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  byte_sr_q;
  logic [7:0]  byte_d;
  logic        byte_done_s;
  logic [3:0]  addr_q;
  logic        fixed_addr_q;
  logic        display_on_q;
  logic [2:0]  brightness_q;
  logic        dio_q;
  logic        dio_oe_q;
  logic        wr_strobe_q;
  logic [3:0]  wr_addr_q;
  logic        frame_err_q;
  logic [31:0] key_sr_q;
  logic [5:0]  rd_cnt_q;
  logic [7:0]  ram_q [16];

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign stb_s = stb_sync_q[SYNC_STAGES-1];
  assign dio_s = dio_sync_q[SYNC_STAGES-1];

  assign clk_rise_s = clk_s & ~clk_prev_q;
  assign clk_fall_s = ~clk_s & clk_prev_q;
  assign stb_rise_s = stb_s & ~stb_prev_q;
  assign stb_fall_s = ~stb_s & stb_prev_q;

  // DIO is synchronized with the same depth as CLK, so the bit sampled on a rise is aligned
  assign byte_d      = {dio_s, byte_sr_q[7:1]};
  assign byte_done_s = (bit_cnt_q == 3'd7);

  // Pin synchronizers and edge-history flops; idle pins read as high
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clk_sync_q <= {SYNC_STAGES{1'b1}};
      stb_sync_q <= {SYNC_STAGES{1'b1}};
      dio_sync_q <= {SYNC_STAGES{1'b1}};
      clk_prev_q <= 1'b1;
      stb_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], i_tm1638_clk};
      stb_sync_q <= {stb_sync_q[SYNC_STAGES-2:0], i_tm1638_stb};
      dio_sync_q <= {dio_sync_q[SYNC_STAGES-2:0], i_tm1638_dio};
      clk_prev_q <= clk_s;
      stb_prev_q <= stb_s;
    end
  end

  // Frame FSM: byte assembly, command decode, RAM writes and key readback
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= 3'd0;
      byte_sr_q    <= 8'd0;
      addr_q       <= 4'd0;
      fixed_addr_q <= 1'b0;
      display_on_q <= 1'b0;
      brightness_q <= 3'd0;
      dio_q        <= 1'b0;
      dio_oe_q     <= 1'b0;
      wr_strobe_q  <= 1'b0;
      wr_addr_q    <= 4'd0;
      frame_err_q  <= 1'b0;
      key_sr_q     <= 32'd0;
      rd_cnt_q     <= 6'd0;
      for (int n = 0; n < 16; n++) begin
        ram_q[n] <= 8'd0;
      end
    end else begin
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
      if (stb_rise_s) begin
        // A strobe rise ends the frame wherever it stands; half-shifted bits are dropped
        if (((state_q == S_CMD) || (state_q == S_WRITE)) && (bit_cnt_q != 3'd0)) begin
          frame_err_q <= 1'b1;
        end
        state_q   <= S_IDLE;
        dio_oe_q  <= 1'b0;
        bit_cnt_q <= 3'd0;
      end else if (stb_fall_s) begin
        state_q   <= S_CMD;
        bit_cnt_q <= 3'd0;
        dio_oe_q  <= 1'b0;
      end else if (!stb_s && (state_q != S_IDLE)) begin
        if (clk_rise_s) begin
          byte_sr_q <= byte_d;
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if ((state_q == S_READ) && (rd_cnt_q != 6'd32)) begin
            rd_cnt_q <= rd_cnt_q + 6'd1;
          end
          if (byte_done_s) begin
            case (state_q)
              S_CMD: begin
                case (byte_d[7:6])
                  2'b01: begin
                    fixed_addr_q <= byte_d[2];
                    if (byte_d[1]) begin
                      state_q  <= S_READ;
                      key_sr_q <= i_key_scan;
                      rd_cnt_q <= 6'd0;
                    end else begin
                      state_q <= S_IGNORE;
                    end
                  end
                  2'b10: begin
                    display_on_q <= byte_d[3];
                    brightness_q <= byte_d[2:0];
                    state_q      <= S_IGNORE;
                  end
                  2'b11: begin
                    addr_q  <= byte_d[3:0];
                    state_q <= S_WRITE;
                  end
                  default: state_q <= S_IGNORE;
                endcase
              end
              S_WRITE: begin
                ram_q[addr_q] <= byte_d;
                wr_strobe_q   <= 1'b1;
                wr_addr_q     <= addr_q;
                if (!fixed_addr_q) begin
                  addr_q <= addr_q + 4'd1;
                end
              end
              default: ;
            endcase
          end
        end else if (clk_fall_s && (state_q == S_READ)) begin
          // The host samples on the next rise, so each bit is launched on the preceding fall
          if (rd_cnt_q == 6'd32) begin
            dio_oe_q <= 1'b0;
          end else begin
            dio_q    <= key_sr_q[0];
            dio_oe_q <= 1'b1;
            key_sr_q <= {1'b0, key_sr_q[31:1]};
          end
        end
      end
    end
  end

  for (genvar n = 0; n < 16; n++) begin : g_ram_out
    assign o_disp_ram[8*n +: 8] = ram_q[n];
  end

  assign o_tm1638_dio    = dio_q;
  assign o_tm1638_dio_oe = dio_oe_q;
  assign o_display_on    = display_on_q;
  assign o_brightness    = brightness_q;
  assign o_wr_strobe     = wr_strobe_q;
  assign o_wr_addr       = wr_addr_q;
  assign o_frame_err     = frame_err_q;
  assign o_idle          = stb_s & (state_q == S_IDLE);

endmodule

// File: tb/tb_tm1638_emu.sv
// Directed bench for tm1638_emu: bit-bangs host frames and checks RAM, control, strobes and readback.
module tb_tm1638_emu;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         hclk = 1'b1;
  logic         hstb = 1'b1;
  logic         hdio = 1'b1;
  logic [31:0]  key_scan = 32'h0400_0180;
  logic         dio_out;
  logic         dio_oe;
  logic [127:0] disp_ram;
  logic         display_on;
  logic [2:0]   brightness;
  logic         wr_strobe;
  logic [3:0]   wr_addr;
  logic         frame_err;
  logic         idle;

  int         tests_run = 0;
  int         tests_failed = 0;
  int         ferr_cnt = 0;
  logic [3:0] wr_log [$];
  logic [7:0] exp_ram [16];

  tm1638_emu #(.SYNC_STAGES(2)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_tm1638_clk    (hclk),
    .i_tm1638_stb    (hstb),
    .i_tm1638_dio    (hdio),
    .o_tm1638_dio    (dio_out),
    .o_tm1638_dio_oe (dio_oe),
    .i_key_scan      (key_scan),
    .o_disp_ram      (disp_ram),
    .o_display_on    (display_on),
    .o_brightness    (brightness),
    .o_wr_strobe     (wr_strobe),
    .o_wr_addr       (wr_addr),
    .o_frame_err     (frame_err),
    .o_idle          (idle)
  );

  always #5 clk = ~clk;

  // Log one-cycle pulses away from the active edge
  always @(negedge clk) begin
    if (wr_strobe) wr_log.push_back(wr_addr);
    if (frame_err) ferr_cnt++;
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pack_exp();
    logic [127:0] r;
    for (int n = 0; n < 16; n++) r[8*n +: 8] = exp_ram[n];
    return r;
  endfunction

  task automatic half_phase();
    repeat (8) @(negedge clk);
  endtask

  task automatic frame_begin();
    hstb = 1'b0;
    half_phase();
  endtask

  task automatic frame_end();
    hclk = 1'b1;
    hdio = 1'b1;
    hstb = 1'b1;
    half_phase();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      hclk = 1'b0;
      hdio = b[i];
      half_phase();
      hclk = 1'b1;
      half_phase();
    end
  endtask

  task automatic one_byte_frame(input logic [7:0] b);
    frame_begin();
    send_bits(b, 8);
    frame_end();
  endtask

  initial begin
    int base;
    logic [31:0] rx;
    for (int n = 0; n < 16; n++) exp_ram[n] = 8'h00;

    repeat (3) @(negedge clk);
    check_eq("rst_oe", dio_oe, 1'b0);
    check_eq("rst_dio", dio_out, 1'b0);
    check_eq("rst_ram", disp_ram, pack_exp());
    check_eq("rst_ctrl", {display_on, brightness}, 4'h0);
    rst_n = 1'b1;
    half_phase();
    check_eq("rst_idle", idle, 1'b1);

    // Auto-increment write from address 0
    one_byte_frame(8'h40);
    base = wr_log.size();
    frame_begin();
    send_bits(8'hC0, 8); send_bits(8'h3F, 8); send_bits(8'h06, 8);
    frame_end();
    exp_ram[0] = 8'h3F; exp_ram[1] = 8'h06;
    check_eq("auto_ram", disp_ram, pack_exp());
    check_eq("auto_nstb", wr_log.size() - base, 2);
    if (wr_log.size() - base == 2) begin
      check_eq("auto_addr0", wr_log[base], 4'd0);
      check_eq("auto_addr1", wr_log[base+1], 4'd1);
    end

    // Fixed addressing: both bytes land at 5
    one_byte_frame(8'h44);
    base = wr_log.size();
    frame_begin();
    send_bits(8'hC5, 8); send_bits(8'hAA, 8); send_bits(8'hBB, 8);
    frame_end();
    exp_ram[5] = 8'hBB;
    check_eq("fix_ram5", disp_ram[47:40], 8'hBB);
    check_eq("fix_ram6", disp_ram[55:48], 8'h00);
    check_eq("fix_ram", disp_ram, pack_exp());
    check_eq("fix_nstb", wr_log.size() - base, 2);
    if (wr_log.size() - base == 2) begin
      check_eq("fix_addr0", wr_log[base], 4'd5);
      check_eq("fix_addr1", wr_log[base+1], 4'd5);
    end

    // Address wrap 15 -> 0
    one_byte_frame(8'h40);
    base = wr_log.size();
    frame_begin();
    send_bits(8'hCF, 8); send_bits(8'h11, 8); send_bits(8'h22, 8); send_bits(8'h33, 8);
    frame_end();
    exp_ram[15] = 8'h11; exp_ram[0] = 8'h22; exp_ram[1] = 8'h33;
    check_eq("wrap_ram", disp_ram, pack_exp());
    check_eq("wrap_nstb", wr_log.size() - base, 3);
    if (wr_log.size() - base == 3) begin
      check_eq("wrap_addr1", wr_log[base+1], 4'd0);
    end

    // Display control
    one_byte_frame(8'h8F);
    check_eq("dc_on", {display_on, brightness}, 4'hF);
    one_byte_frame(8'h80);
    check_eq("dc_off", {display_on, brightness}, 4'h0);
    check_eq("dc_ram", disp_ram, pack_exp());

    // Key readback, host samples on each rise
    frame_begin();
    send_bits(8'h42, 8);
    rx = 32'd0;
    for (int i = 0; i < 32; i++) begin
      hclk = 1'b0;
      half_phase();
      hclk = 1'b1;
      rx[i] = dio_out;
      if (i == 0 || i == 31) check_eq("rd_oe_on", dio_oe, 1'b1);
      half_phase();
    end
    check_eq("rd_byte0", rx[7:0], 8'h80);
    check_eq("rd_byte1", rx[15:8], 8'h01);
    check_eq("rd_byte2", rx[23:16], 8'h00);
    check_eq("rd_byte3", rx[31:24], 8'h04);
    hclk = 1'b0;
    half_phase();
    check_eq("rd_oe_end", dio_oe, 1'b0);
    hclk = 1'b1;
    half_phase();
    frame_end();
    check_eq("rd_oe_stb", dio_oe, 1'b0);
    check_eq("rd_idle", idle, 1'b1);

    // Aborted partial byte
    base = wr_log.size();
    frame_begin();
    send_bits(8'hC3, 8);
    send_bits(8'hFF, 3);
    frame_end();
    check_eq("ferr_cnt", ferr_cnt, 1);
    check_eq("ferr_nowr", wr_log.size() - base, 0);
    check_eq("ferr_ram", disp_ram, pack_exp());

    // Reset in the middle of a read releases DIO at once
    frame_begin();
    send_bits(8'h42, 8);
    hclk = 1'b0;
    half_phase();
    check_eq("mid_oe_on", dio_oe, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_oe_rst", dio_oe, 1'b0);
    hclk = 1'b1; hdio = 1'b1; hstb = 1'b1;
    half_phase();
    rst_n = 1'b1;
    half_phase();
    for (int n = 0; n < 16; n++) exp_ram[n] = 8'h00;
    check_eq("post_rst_ram", disp_ram, pack_exp());
    base = wr_log.size();
    frame_begin();
    send_bits(8'hC2, 8); send_bits(8'h5A, 8); send_bits(8'hA5, 8);
    frame_end();
    exp_ram[2] = 8'h5A; exp_ram[3] = 8'hA5;
    check_eq("post_rst_wr", disp_ram, pack_exp());
    check_eq("post_rst_nstb", wr_log.size() - base, 2);
    if (wr_log.size() - base == 2) begin
      check_eq("post_rst_addr", {wr_log[base], wr_log[base+1]}, 8'h23);
    end
    check_eq("post_rst_idle", idle, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/tm1638_emu.md
TM1638_EMU -- requirements
Module: tm1638_emu

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on each shield-pin input (minimum 2).
REQ-002 SHALL have port i_clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port i_tm1638_clk  input  1  serial clock from the host driver.
REQ-005 SHALL have port i_tm1638_stb  input  1  frame strobe, active low.
REQ-006 SHALL have port i_tm1638_dio  input  1  serial data from the host.
REQ-007 SHALL have port o_tm1638_dio  output  1  serial data toward the host, valid when o_tm1638_dio_oe=1.
REQ-008 SHALL have port o_tm1638_dio_oe  output  1  DIO drive enable.
REQ-009 SHALL have port i_key_scan  input  32  key-scan bytes; byte0=[7:0] is shifted first.
REQ-010 SHALL have port o_disp_ram  output  128  display RAM; byte n = [8n+7:8n].
REQ-011 SHALL have port o_display_on  output  1  display-control on bit.
REQ-012 SHALL have port o_brightness  output  3  display-control brightness.
REQ-013 SHALL have port o_wr_strobe  output  1  one-cycle pulse on each RAM byte write.
REQ-014 SHALL have port o_wr_addr  output  4  address of the byte written, valid with o_wr_strobe.
REQ-015 SHALL have port o_frame_err  output  1  one-cycle pulse on an aborted partial byte.
REQ-016 SHALL have port o_idle  output  1  high when the synchronized STB is high and the FSM is in S_IDLE.

Function
REQ-017 SHALL synchronize CLK, STB and DIO through SYNC_STAGES flops, then edge-detect the synced CLK into single-cycle rise and fall events.
REQ-018 SHALL support host CLK high and low phases of at least SYNC_STAGES+2 i_clk cycles each; shorter phases are unsupported.
REQ-019 SHALL use FSM states S_IDLE, S_CMD, S_WRITE, S_READ, S_IGNORE.
REQ-020 SHALL move S_IDLE -> S_CMD on the synced STB falling edge and clear the bit counter.
REQ-021 SHALL sample DIO on every CLK rise while STB is low, shifting LSB first; the 8th bit completes the byte.
REQ-022 SHALL decode the first byte of a frame as a command.
REQ-023 SHALL handle command [7:6]=01 (data command) as follows: bit1 sets read mode, bit2 sets fixed addressing (0 = auto-increment); the mode persists across frames; read mode -> S_READ, write mode -> S_IGNORE.
REQ-024 SHALL handle command [7:6]=10 by setting o_display_on=bit3 and o_brightness=bits[2:0], then -> S_IGNORE.
REQ-025 SHALL handle command [7:6]=11 by loading the address register with bits[3:0], then -> S_WRITE.
REQ-026 SHALL handle command [7:6]=00 by going -> S_IGNORE.
REQ-027 SHALL, in S_WRITE, write each completed byte to RAM[addr] and pulse o_wr_strobe with o_wr_addr=addr in the same cycle that o_disp_ram updates.
REQ-028 SHALL, in S_WRITE with auto-increment, then set addr=addr+1 modulo 16 (15 wraps to 0); with fixed addressing, addr is unchanged.
REQ-029 SHALL update RAM within SYNC_STAGES+2 i_clk cycles of the 8th CLK rise at the pins.
REQ-030 SHALL, on entry to S_READ, snapshot i_key_scan into a 32-bit shift register.
REQ-031 SHALL, in S_READ, drive shift-register bit0 on each CLK fall with oe=1, then shift right; the first fall after the command byte drives bit0.
REQ-032 SHALL, in S_READ, deassert oe at the first CLK fall after the 32nd CLK rise; later clocks leave DIO undriven.
REQ-033 SHALL ignore all bytes in S_IGNORE.
REQ-034 SHALL, on a synced STB rise from any state, clear oe, return to S_IDLE, and discard any partial byte.
REQ-035 SHALL pulse o_frame_err on a synced STB rise when the bit counter is nonzero in S_CMD or S_WRITE.
REQ-036 SHALL ignore CLK edges and DIO while STB is high.

Reset
REQ-037 SHALL, while i_rst_n=0, set immediately: state S_IDLE; RAM all 0; addr 0; auto-increment write mode; o_display_on=0; o_brightness=0; o_tm1638_dio_oe=0; o_tm1638_dio=0; o_wr_strobe=0; o_frame_err=0; synchronizer flops to STB=1, CLK=1, DIO=1.
REQ-038 SHALL, when reset asserts mid-read, release DIO asynchronously; the first frame after reset starts cleanly on the next STB fall.

Verification
REQ-039 SHALL cover: frame 0x40; frame 0xC0,0x3F,0x06 -> RAM[0]=0x3F, RAM[1]=0x06; two o_wr_strobe pulses with addr 0 then 1.
REQ-040 SHALL cover: frame 0x44; frame 0xC5,0xAA,0xBB -> RAM[5]=0xBB, RAM[6]=0x00; two strobes, both with addr 5.
REQ-041 SHALL cover: frame 0x40; frame 0xCF,0x11,0x22,0x33 -> RAM[15]=0x11, RAM[0]=0x22, RAM[1]=0x33 (wrap).
REQ-042 SHALL cover: frame 0x8F -> display_on=1, brightness=7; then frame 0x80 -> display_on=0, brightness=0; RAM unchanged.
REQ-043 SHALL cover: i_key_scan=0x04000180; frame 0x42 plus 32 clocks, host samples on rise -> host receives 0x80,0x01,0x00,0x04; oe=0 after the 32nd bit and after STB rise.
REQ-044 SHALL cover: frame 0xC3 plus 3 data bits, then STB high -> one o_frame_err pulse, no write; reset asserted mid-read -> oe=0 immediately, then a normal frame works.
